riscv_fetch_unit: RTL and testbench

Instruction-fetch and program-counter stage of the multicycle RISC-V core, directly upstream of the control FSM. It owns the PC, the old-PC register and the instruction register. It runs a request/acknowledge read on instruction memory whenever the FSM asserts `IRWrite`, and feeds `opcode`/`funct3` back to the FSM. While a fetch is outstanding it raises `stall`, which top level uses to freeze the FSM and the datapath.

---
 rtl/riscv_fetch_unit.sv | 145 ++++++++++++++
 tb/tb_riscv_fetch_unit.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_fetch_unit.sv
// Instruction fetch / PC stage: owns pc, old_pc and the instruction register, runs a req/ack imem read.
// Optional macro FETCH_TIMEOUT_EN adds a bounded wait on imem_ack that faults the fetch on expiry.
module riscv_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ir_write,
    input  logic        pc_write,
    input  logic        pc_src,
    input  logic        bbeq,
    input  logic        bbne,
    input  logic        alu_zero,
    input  logic [31:0] alu_result,
    input  logic [31:0] alu_out,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        stall,
    output logic [31:0] pc,
    output logic [31:0] old_pc,
    output logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic        fetch_err
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] old_pc_q, old_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] addr_q, addr_d;
    logic        req_q, req_d;
    logic        err_q, err_d;
    logic        taken, pc_en;

    if (TIMEOUT == 0) begin : g_bad_timeout
        $error("riscv_fetch_unit: TIMEOUT must be at least 1");
    end

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned    CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(TIMEOUT);
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    assign stall = (state_q == S_IDLE && ir_write) || (state_q == S_WAIT);
    assign taken = (bbeq & alu_zero) | (bbne & ~alu_zero);
    // PC frozen while a fetch is pending so alu_result still holds fetched PC+4 in DONE
    assign pc_en = (pc_write | taken) & ~stall;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        old_pc_d = old_pc_q;
        instr_d  = instr_q;
        addr_d   = addr_q;
        req_d    = req_q;
        err_d    = err_q;
`ifdef FETCH_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (ir_write) begin
                    if (pc_q[1:0] == 2'b00) begin
                        state_d = S_WAIT;
                        req_d   = 1'b1;
                        addr_d  = pc_q;
`ifdef FETCH_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        // misaligned: load zero so the FSM decodes HALT
                        instr_d = '0;
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_WAIT: begin
`ifdef FETCH_TIMEOUT_EN
                cnt_d = cnt_q + CW'(1);
`endif
                if (imem_ack) begin
                    instr_d  = imem_rdata;
                    old_pc_d = pc_q;
                    req_d    = 1'b0;
                    state_d  = S_DONE;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (cnt_d == CNT_MAX) begin
                    instr_d = '0;
                    err_d   = 1'b1;
                    req_d   = 1'b0;
                    state_d = S_DONE;
                end
`endif
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (pc_en) pc_d = pc_src ? alu_out : alu_result;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            old_pc_q <= RESET_PC;
            instr_q  <= '0;
            addr_q   <= '0;
            req_q    <= 1'b0;
            err_q    <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            old_pc_q <= old_pc_d;
            instr_q  <= instr_d;
            addr_q   <= addr_d;
            req_q    <= req_d;
            err_q    <= err_d;
`ifdef FETCH_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign pc        = pc_q;
    assign old_pc    = old_pc_q;
    assign instr     = instr_q;
    assign opcode    = instr_q[6:0];
    assign funct3    = instr_q[14:12];
    assign fetch_err = err_q;

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Bench for riscv_fetch_unit: fetch-transaction reference model checked every cycle,
// directed literal scenarios, then randomized traffic with stray acks and reset pulses.
module tb_riscv_fetch_unit;

    localparam logic [31:0] RPC = 32'h0040_0000;
    localparam int          TO  = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ir_write = 1'b0, pc_write = 1'b0, pc_src = 1'b0;
    logic        bbeq = 1'b0, bbne = 1'b0, alu_zero = 1'b0;
    logic [31:0] alu_result = '0, alu_out = '0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_req, stall, fetch_err;
    logic [31:0] imem_addr, pc, old_pc, instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;

    int checks = 0, failures = 0;
    bit chk_en = 1'b0;

    // memory responder controls
    int          mem_delay = 0;
    logic [31:0] mem_data = '0;
    bit          rand_en = 1'b0, stray_en = 1'b0, force_ack = 1'b0;

    always #5 clk = ~clk;

    riscv_fetch_unit #(.RESET_PC(RPC), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .bbeq(bbeq), .bbne(bbne), .alu_zero(alu_zero),
        .alu_result(alu_result), .alu_out(alu_out), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall(stall), .pc(pc), .old_pc(old_pc), .instr(instr),
        .opcode(opcode), .funct3(funct3), .fetch_err(fetch_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (fetch transaction view) ----------------
    logic [31:0] m_pc = RPC, m_old_pc = RPC, m_instr = '0, m_addr = '0;
    bit          m_err = 1'b0, m_pend = 1'b0, m_done = 1'b0;
    int          m_wait = 0;
    wire         m_stall = m_pend | (~m_pend & ~m_done & ir_write);
    wire         m_taken = (bbeq & alu_zero) | (bbne & ~alu_zero);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc <= RPC; m_old_pc <= RPC; m_instr <= '0; m_addr <= '0;
            m_err <= 1'b0; m_pend <= 1'b0; m_done <= 1'b0; m_wait <= 0;
        end else begin
            if (m_pend) begin
                m_wait <= m_wait + 1;
                if (imem_ack) begin
                    m_instr <= imem_rdata; m_old_pc <= m_pc;
                    m_pend <= 1'b0; m_done <= 1'b1;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (m_wait + 1 == TO) begin
                    m_instr <= '0; m_err <= 1'b1;
                    m_pend <= 1'b0; m_done <= 1'b1;
                end
`endif
            end else if (m_done) begin
                m_done <= 1'b0;
            end else if (ir_write) begin
                if (m_pc % 4 == 0) begin
                    m_pend <= 1'b1; m_addr <= m_pc; m_wait <= 0;
                end else begin
                    m_instr <= '0; m_err <= 1'b1; m_done <= 1'b1;
                end
            end
            if ((pc_write || m_taken) && !m_stall)
                m_pc <= pc_src ? alu_out : alu_result;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pc", pc, m_pc);
            chk("old_pc", old_pc, m_old_pc);
            chk("instr", instr, m_instr);
            chk("opcode", {25'd0, opcode}, {25'd0, m_instr[6:0]});
            chk("funct3", {29'd0, funct3}, {29'd0, m_instr[14:12]});
            chk("imem_req", {31'd0, imem_req}, {31'd0, m_pend});
            chk("imem_addr", imem_addr, m_addr);
            chk("stall", {31'd0, stall}, {31'd0, m_stall});
            chk("fetch_err", {31'd0, fetch_err}, {31'd0, m_err});
        end
    end

    // ---------------- memory responder ----------------
    initial begin
        int acnt;
        acnt = 0;
        forever begin
            @(posedge clk);
            #2;
            imem_rdata = rand_en ? $urandom : mem_data;
            if (imem_req) begin
                imem_ack = (acnt >= mem_delay);
                acnt++;
            end else begin
                acnt = 0;
                imem_ack = force_ack || (stray_en && $urandom_range(0, 3) == 0);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    // Raise ir_write until the fetch reaches DONE; sample at the DONE negedge.
    task automatic fetch(input logic [31:0] exp_pc, input logic [31:0] exp_addr,
                         output int nstall, output int nreq);
        bit done;
        done = 1'b0;
        nstall = 0;
        nreq = 0;
        ir_write = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!stall) begin
                done = 1'b1;
                break;
            end
            nstall++;
            chk("pc_frozen", pc, exp_pc);
            if (imem_req) begin
                nreq++;
                chk("addr_stable", imem_addr, exp_addr);
            end
        end
        if (!done) chk("fetch_bound", 32'd0, 32'd1);
    endtask

    task automatic end_fetch();
        step();
        ir_write = 1'b0;
    endtask

    initial begin
        int ns, nr;
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk("rst_pc", pc, RPC);
        chk("rst_old_pc", old_pc, RPC);
        chk("rst_instr", instr, 32'h0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_err", {31'd0, fetch_err}, 32'd0);
        rst_n = 1'b1;

        // zero-wait fetch, pc_write held: PC may only move in DONE
        mem_delay = 0; mem_data = 32'h0000_0033;
        pc_write = 1'b1; alu_result = RPC + 32'd4;
        fetch(RPC, RPC, ns, nr);
        chk("zw_stall_cycles", ns, 32'd2);
        chk("zw_addr", imem_addr, RPC);
        chk("zw_opcode", {25'd0, opcode}, 32'h33);
        chk("zw_old_pc", old_pc, RPC);
        end_fetch();
        pc_write = 1'b0;
        chk("zw_pc_next", pc, 32'h0040_0004);

        // ack arrives 5 cycles after ir_write (4 wait states)
        mem_delay = 4; mem_data = 32'h00A0_0093;
        pc_write = 1'b1; alu_result = 32'h0040_0008;
        fetch(32'h0040_0004, 32'h0040_0004, ns, nr);
        chk("slow_stall_cycles", ns, 32'd6);
        chk("slow_instr", instr, 32'h00A0_0093);
        chk("slow_funct3", {29'd0, funct3}, 32'd0);
        end_fetch();
        pc_write = 1'b0;
        chk("slow_pc_next", pc, 32'h0040_0008);

        // bne taken / not taken
        bbne = 1'b1; alu_zero = 1'b0; pc_src = 1'b1; alu_out = 32'h0040_0020;
        step();
        chk("bne_taken", pc, 32'h0040_0020);
        alu_zero = 1'b1; alu_out = 32'h0040_0040;
        step();
        chk("bne_not_taken", pc, 32'h0040_0020);
        bbne = 1'b0;

        // pc_write and beq taken together: one update via pc_src
        bbeq = 1'b1; alu_zero = 1'b1; pc_write = 1'b1;
        alu_out = 32'h0040_0080; alu_result = 32'h0040_0090;
        step();
        chk("both_update", pc, 32'h0040_0080);
        bbeq = 1'b0; pc_src = 1'b0;

        // misaligned JALR target, then a fetch from it
        alu_result = 32'h0040_0102;
        step();
        pc_write = 1'b0;
        chk("jalr_pc", pc, 32'h0040_0102);
        fetch(32'h0040_0102, 32'h0040_0004, ns, nr);
        chk("mis_stall_cycles", ns, 32'd1);
        chk("mis_no_req", nr, 32'd0);
        chk("mis_instr", instr, 32'h0);
        chk("mis_err", {31'd0, fetch_err}, 32'd1);
        end_fetch();
        chk("mis_err_sticky", {31'd0, fetch_err}, 32'd1);

`ifdef FETCH_TIMEOUT_EN
        reset_pulse();
        mem_delay = 1000;
        fetch(RPC, RPC, ns, nr);
        chk("to_stall_cycles", ns, 32'd17);
        chk("to_wait_cycles", nr, 32'd16);
        chk("to_err", {31'd0, fetch_err}, 32'd1);
        chk("to_instr", instr, 32'h0);
        end_fetch();
        reset_pulse();
        chk("to_rst_err", {31'd0, fetch_err}, 32'd0);
        chk("to_rst_pc", pc, RPC);
`endif

        // reset while waiting on memory, then a late ack
        reset_pulse();
        mem_delay = 1000; mem_data = 32'hDEAD_BEEF;
        ir_write = 1'b1;
        step();
        chk("wait_req_high", {31'd0, imem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("req_async_drop", {31'd0, imem_req}, 32'd0);
        step();
        rst_n = 1'b1; ir_write = 1'b0; force_ack = 1'b1;
        step();
        force_ack = 1'b0;
        step();
        chk("late_ack_instr", instr, 32'h0);
        chk("late_ack_err", {31'd0, fetch_err}, 32'd0);

        // randomized traffic
        rand_en = 1'b1; stray_en = 1'b1;
        for (int c = 0; c < 2500; c++) begin
            logic [31:0] r;
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
            ir_write = ($urandom_range(0, 2) == 0);
            pc_write = ($urandom_range(0, 3) == 0);
            bbeq = ($urandom_range(0, 7) == 0);
            bbne = ($urandom_range(0, 7) == 0);
            alu_zero = $urandom_range(0, 1);
            pc_src = $urandom_range(0, 1);
            r = $urandom;
            alu_result = ($urandom_range(0, 15) == 0) ? r : (r & 32'hFFFF_FFFC);
            r = $urandom;
            alu_out = ($urandom_range(0, 15) == 0) ? r : (r & 32'hFFFF_FFFC);
            mem_delay = $urandom_range(0, 5);
            step();
        end
        rst_n = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
